// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: two-flop synchroniser, per-channel persistence
// filter and x4 decoder producing a registered step/dir/err for the counter.
module quad_step_decoder #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a_in,
  input  logic b_in,
  output logic step,
  output logic dir,
  output logic err,
  output logic a_filt,
  output logic b_filt
);

  localparam int unsigned     CW        = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0]   FILT_LAST = CW'(FILT_LEN - 1);

  // Channel vectors are packed {A, B}.
  logic [1:0]    sync_p0;
  logic [1:0]    sync_p1;
  logic [1:0]    filt_p2;
  logic [1:0]    prev_p3;
  logic [CW-1:0] fcnt_p2 [2];
  logic [1:0]    start_cnt;
  logic [1:0]    delta;
  logic          run;

  // For a single-bit change in the 00->10->11->01 order, the move is "up"
  // exactly when the old A equals the new B.
  function automatic logic is_up(input logic prev_a, input logic cur_b);
    return prev_a ~^ cur_b;
  endfunction

  assign run    = (start_cnt == 2'd3);
  assign delta  = prev_p3 ^ filt_p2;
  assign a_filt = filt_p2[1];
  assign b_filt = filt_p2[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      filt_p2    <= '0;
      prev_p3    <= '0;
      fcnt_p2[0] <= '0;
      fcnt_p2[1] <= '0;
      start_cnt  <= '0;
      step       <= 1'b0;
      err        <= 1'b0;
      dir        <= 1'b1;
    end else begin
      // p0/p1: synchroniser
      sync_p0 <= {a_in, b_in};
      sync_p1 <= sync_p0;
      step    <= 1'b0;
      err     <= 1'b0;
      if (!run) begin
        start_cnt <= start_cnt + 2'd1;
      end
      if (start_cnt == 2'd2) begin
        // Seed filter and history from the first valid synchronised sample
        filt_p2 <= sync_p1;
        prev_p3 <= sync_p1;
      end else if (run) begin
        // p2: persistence filter
        for (int i = 0; i < 2; i++) begin
          if (sync_p1[i] == filt_p2[i]) begin
            fcnt_p2[i] <= '0;
          end else if (fcnt_p2[i] == FILT_LAST) begin
            filt_p2[i] <= sync_p1[i];
            fcnt_p2[i] <= '0;
          end else begin
            fcnt_p2[i] <= fcnt_p2[i] + CW'(1);
          end
        end
        // p3: decode against the previous filtered state
        prev_p3 <= filt_p2;
        if (en && (delta == 2'b01 || delta == 2'b10)) begin
          step <= 1'b1;
          dir  <= is_up(prev_p3[1], filt_p2[0]);
        end else if (en && (delta == 2'b11)) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: segment table, hand-written reset/seed and
// async-reset sequences, and randomized stimulus against a reference model.
module tb_quad_step_decoder;

  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst, en, a_in, b_in;
  logic step, dir, err, a_filt, b_filt;

  quad_step_decoder #(.FILT_LEN(FL)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a_in   (a_in),
    .b_in   (b_in),
    .step   (step),
    .dir    (dir),
    .err    (err),
    .a_filt (a_filt),
    .b_filt (b_filt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ctr = 0;

  // Reference model: encoder position is a Gray index, movement is the index delta.
  int         m_n;
  logic [1:0] m_s1, m_s2, m_filt, m_prev;
  int         m_run [2];
  logic       m_step, m_err, m_dir;

  function automatic int pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_n = 0; m_s1 = '0; m_s2 = '0; m_filt = '0; m_prev = '0;
    m_run[0] = 0; m_run[1] = 0;
    m_step = 1'b0; m_err = 1'b0; m_dir = 1'b1;
  endtask

  task automatic model_edge();
    logic [1:0] nf;
    int d;
    m_step = 1'b0;
    m_err  = 1'b0;
    m_n++;
    if (m_n == 3) begin
      m_filt = m_s2;
      m_prev = m_s2;
    end else if (m_n >= 4) begin
      nf = m_filt;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] !== m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] == FL) begin
            nf[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      d = (pos(m_filt) - pos(m_prev) + 4) % 4;
      if (en) begin
        if (d == 1) begin m_step = 1'b1; m_dir = 1'b1; end
        else if (d == 3) begin m_step = 1'b1; m_dir = 1'b0; end
        else if (d == 2) m_err = 1'b1;
      end
      m_prev = m_filt;
      m_filt = nf;
    end
    m_s2 = m_s1;
    m_s1 = {a_in, b_in};
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_all(input string nm);
    logic [4:0] act, exp;
    act = {step, err, dir, a_filt, b_filt};
    exp = {m_step, m_err, m_dir, m_filt[1], m_filt[0]};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: {step,err,dir,a_filt,b_filt} got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    #1;
    model_edge();
    cmp_all(nm);
    if (step) ctr += dir ? 1 : -1;
  endtask

  task automatic do_reset(input logic a, input logic b);
    rst = 1'b0; a_in = a; b_in = b; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    cmp_all("in_reset");
    rst = 1'b1;
  endtask

  typedef struct {
    logic a; logic b; logic e;
    int cyc; int n_up; int n_dn; int n_err; int first;
  } seg_t;

  seg_t segs [19];

  initial begin
    int nu, nd, ne, first;
    rst = 1'b0; a_in = 1'b0; b_in = 1'b0; en = 1'b1;

    segs = '{
      '{1'b0, 1'b0, 1'b1, 12, 0, 0, 0, -1},  // idle after seed
      '{1'b1, 1'b0, 1'b1, 10, 1, 0, 0,  6},  // forward rotation
      '{1'b1, 1'b1, 1'b1, 10, 1, 0, 0, -1},
      '{1'b0, 1'b1, 1'b1, 10, 1, 0, 0, -1},
      '{1'b0, 1'b0, 1'b1, 10, 1, 0, 0, -1},
      '{1'b0, 1'b1, 1'b1, 10, 0, 1, 0, -1},  // reverse
      '{1'b1, 1'b1, 1'b1, 10, 0, 1, 0, -1},
      '{1'b0, 1'b1, 1'b1, 10, 1, 0, 0, -1},  // reversal
      '{1'b0, 1'b0, 1'b1, 10, 1, 0, 0, -1},
      '{1'b1, 1'b0, 1'b1,  3, 0, 0, 0, -1},  // 3-cycle glitch
      '{1'b0, 1'b0, 1'b1, 12, 0, 0, 0, -1},
      '{1'b1, 1'b0, 1'b1,  4, 0, 0, 0, -1},  // 4-cycle pulse
      '{1'b0, 1'b0, 1'b1, 14, 1, 1, 0, -1},
      '{1'b1, 1'b1, 1'b1, 10, 0, 0, 1, -1},  // illegal
      '{1'b0, 1'b0, 1'b1, 10, 0, 0, 1, -1},
      '{1'b1, 1'b0, 1'b0, 10, 0, 0, 0, -1},  // gated
      '{1'b1, 1'b1, 1'b0, 10, 0, 0, 0, -1},
      '{1'b0, 1'b1, 1'b1, 10, 1, 0, 0, -1},  // re-enabled
      '{1'b0, 1'b0, 1'b1, 10, 1, 0, 0, -1}
    };

    // Reset and seed with both channels high
    do_reset(1'b1, 1'b1);
    checki("rst_dir", dir, 1);
    for (int t = 1; t <= 3; t++) begin
      tick("seed");
      checki($sformatf("seed_a_filt_e%0d", t), a_filt, (t == 3) ? 1 : 0);
      checki($sformatf("seed_b_filt_e%0d", t), b_filt, (t == 3) ? 1 : 0);
    end
    for (int t = 0; t < 8; t++) begin
      tick("seed_hold");
      checki("seed_no_pulse", step | err, 0);
    end

    // Table-driven segments from a 00 seed
    do_reset(1'b0, 1'b0);
    ctr = 0;
    for (int s = 0; s < $size(segs); s++) begin
      a_in = segs[s].a; b_in = segs[s].b; en = segs[s].e;
      nu = 0; nd = 0; ne = 0; first = -1;
      for (int t = 0; t < segs[s].cyc; t++) begin
        tick($sformatf("seg%0d", s));
        if (step) begin
          if (dir) nu++; else nd++;
          if (first < 0) first = t;
        end
        if (err) ne++;
      end
      checki($sformatf("seg%0d_up", s), nu, segs[s].n_up);
      checki($sformatf("seg%0d_dn", s), nd, segs[s].n_dn);
      checki($sformatf("seg%0d_err", s), ne, segs[s].n_err);
      if (segs[s].first >= 0) checki($sformatf("seg%0d_latency", s), first, segs[s].first);
      if (s == 4) checki("counter_fwd", ctr, 4);
    end

    // Randomized stimulus against the model
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(5, 0) == 0) a_in = ~a_in;
      if ($urandom_range(5, 0) == 0) b_in = ~b_in;
      en = ($urandom_range(9, 0) != 0);
      tick("random");
    end

    // Asynchronous reset while step is high, a_filt/b_filt = 1, dir = 0
    do_reset(1'b0, 1'b0);
    repeat (6) tick("pre_async");
    b_in = 1'b1;
    for (int t = 0; t < 20 && !step; t++) tick("wait_dn1");
    checki("async_setup_step1", step, 1);
    a_in = 1'b1;
    for (int t = 0; t < 20 && !step; t++) tick("wait_dn2");
    checki("async_setup_step2", step, 1);
    checki("async_setup_dir", dir, 0);
    #2;
    rst = 1'b0;
    #1;
    checki("async_step", step, 0);
    checki("async_err", err, 0);
    checki("async_a_filt", a_filt, 0);
    checki("async_b_filt", b_filt, 0);
    checki("async_dir", dir, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
